// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM RX definitions: common sample width and the clog2-based width helper.
package ofdm_rx_pkg;

  localparam int unsigned SAMPLE_W = 32;

  // Width needed to encode values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dly_stage.sv
// One delay-line stage: WIDTH data bits plus a valid bit, with reset, flush and enable.
module dly_stage
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ena,
  input  logic [WIDTH-1:0] dat_in,
  input  logic             val_in,
  output logic [WIDTH-1:0] dat_out,
  output logic             val_out
);

  logic [WIDTH-1:0] dat_q;
  logic             val_q;

  // Flush drops validity only; stale data stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
      val_q <= 1'b0;
    end else if (flush) begin
      val_q <= 1'b0;
    end else if (ena) begin
      dat_q <= dat_in;
      val_q <= val_in;
    end
  end

  assign dat_out = dat_q;
  assign val_out = val_q;

endmodule

// File: rtl/delay_line_var.sv
// Runtime-selectable, stall-aware delay line with per-sample valid and flush.
// Optional DLY_PRIMED_EN adds a fill counter and the primed output.
module delay_line_var
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned SEL_W = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             flush,
  input  logic [SEL_W-1:0] dly_sel,
  input  logic [WIDTH-1:0] dat_in,
  input  logic             val_in,
  output logic [WIDTH-1:0] dat_out,
  output logic             val_out
`ifdef DLY_PRIMED_EN
  ,
  output logic             primed
`endif
);

  // chain[0] is the input; chain[k+1] is the output of stage k.
  logic [WIDTH-1:0] chain_dat [DEPTH+1];
  logic             chain_val [DEPTH+1];
  logic [SEL_W-1:0] sel_clamped;

  assign chain_dat[0] = dat_in;
  assign chain_val[0] = val_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dly_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .ena     (ena),
      .dat_in  (chain_dat[k]),
      .val_in  (chain_val[k]),
      .dat_out (chain_dat[k+1]),
      .val_out (chain_val[k+1])
    );
  end

  // Out-of-range taps (non power-of-two DEPTH) fall back to the last stage.
  always_comb begin
    sel_clamped = dly_sel;
    if (dly_sel > SEL_W'(DEPTH - 1)) begin
      sel_clamped = SEL_W'(DEPTH - 1);
    end
  end

  always_comb begin
    dat_out = '0;
    val_out = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sel_clamped == SEL_W'(k)) begin
        dat_out = chain_dat[k+1];
        val_out = chain_val[k+1];
      end
    end
  end

`ifdef DLY_PRIMED_EN
  localparam int unsigned FILL_W = clog2_min1(DEPTH + 1);

  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = '0;
    end else if (ena && (fill_q != FILL_W'(DEPTH))) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign primed = (32'(fill_q) > 32'(sel_clamped));
`endif

endmodule

// File: tb/tb_delay_line_var.sv
// Scoreboard bench for delay_line_var: DEPTH 16, 12 and 1 instances share stimulus
// and are checked against a sample-log reference model.
module tb_delay_line_var;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  dly_sel = '0;
  logic [31:0] dat_in = '0;
  logic        val_in = 1'b0;

  logic [31:0] dat16, dat12, dat1;
  logic        val16, val12, val1;
  logic        primed16, primed12, primed1;

  always #5 clk = ~clk;

  delay_line_var #(.WIDTH(32), .DEPTH(16)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .flush   (flush),
    .dly_sel (dly_sel),
    .dat_in  (dat_in),
    .val_in  (val_in),
    .dat_out (dat16),
    .val_out (val16)
`ifdef DLY_PRIMED_EN
    ,
    .primed  (primed16)
`endif
  );

  delay_line_var #(.WIDTH(32), .DEPTH(12)) u_dut12 (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .flush   (flush),
    .dly_sel (dly_sel),
    .dat_in  (dat_in),
    .val_in  (val_in),
    .dat_out (dat12),
    .val_out (val12)
`ifdef DLY_PRIMED_EN
    ,
    .primed  (primed12)
`endif
  );

  delay_line_var #(.WIDTH(32), .DEPTH(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .flush   (flush),
    .dly_sel (dly_sel[0]),
    .dat_in  (dat_in),
    .val_in  (val_in),
    .dat_out (dat1),
    .val_out (val1)
`ifdef DLY_PRIMED_EN
    ,
    .primed  (primed1)
`endif
  );

`ifndef DLY_PRIMED_EN
  assign primed16 = 1'b0;
  assign primed12 = 1'b0;
  assign primed1  = 1'b0;
`endif

  // Reference model: log of every accepted sample since reset, tagged with the
  // flush epoch it was written in. A tap of s reads the sample s entries back.
  typedef struct {
    logic [31:0] dat;
    logic        val;
    int unsigned ep;
  } ent_t;

  typedef struct {
    logic [31:0] d16, d12, d1;
    logic        v16, v12, v1;
    logic        p16, p12, p1;
  } exp_t;

  ent_t        log_q[$];
  exp_t        exp_q[$];
  int unsigned epoch = 0;
  int unsigned since = 0;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic void tap(input int unsigned depth, input int unsigned sel,
                              output logic [31:0] od, output logic ov, output logic op);
    int unsigned s;
    int          idx;
    s   = (sel > depth - 1) ? depth - 1 : sel;
    idx = int'(log_q.size()) - 1 - int'(s);
    if (idx < 0) begin
      od = '0;
      ov = 1'b0;
    end else begin
      od = log_q[idx].dat;
      ov = log_q[idx].val && (log_q[idx].ep == epoch);
    end
    op = (since > s);
  endfunction

  task automatic step(input logic r, input logic f, input logic e, input logic v,
                      input logic [31:0] dt, input logic [3:0] s);
    ent_t ent;
    exp_t x;
    @(negedge clk);
    rst     = r;
    flush   = f;
    ena     = e;
    val_in  = v;
    dat_in  = dt;
    dly_sel = s;
    if (r) begin
      log_q.delete();
      epoch = 0;
      since = 0;
    end else if (f) begin
      epoch++;
      since = 0;
    end else if (e) begin
      ent.dat = dt;
      ent.val = v;
      ent.ep  = epoch;
      log_q.push_back(ent);
      since++;
    end
    tap(16, int'(s), x.d16, x.v16, x.p16);
    tap(12, int'(s), x.d12, x.v12, x.p12);
    tap(1, 0, x.d1, x.v1, x.p1);
    exp_q.push_back(x);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, expv);
    end
  endtask

  // Monitor: outputs are live every cycle, so each expected entry matches one edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dat16", dat16, e.d16);
        check("val16", 32'(val16), 32'(e.v16));
        check("dat12", dat12, e.d12);
        check("val12", 32'(val12), 32'(e.v12));
        check("dat1", dat1, e.d1);
        check("val1", 32'(val1), 32'(e.v1));
`ifdef DLY_PRIMED_EN
        check("primed16", 32'(primed16), 32'(e.p16));
        check("primed12", 32'(primed12), 32'(e.p12));
        check("primed1", 32'(primed1), 32'(e.p1));
`endif
      end
    end
  end

  initial begin
    logic [3:0] sel;
    // Reset with live input present
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 32'hDEAD_BEEF, 4'd4);
    // Fixed delay 4 with counting data
    for (int i = 1; i <= 20; i++) step(0, 0, 1, 1, 32'(i), 4'd4);
    // Stall pattern at delay 2
    step(1, 0, 0, 0, 32'h0, 4'd2);
    step(0, 0, 1, 1, 32'hA, 4'd2);
    step(0, 0, 0, 1, $urandom, 4'd2);
    step(0, 0, 0, 1, $urandom, 4'd2);
    step(0, 0, 1, 1, 32'hB, 4'd2);
    step(0, 0, 1, 1, 32'hC, 4'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'(100 + i), 4'd2);
    // Flush at delay 7, sample in the flush cycle is dropped
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, $urandom, 4'd7);
    step(0, 1, 1, 1, 32'h5555_5555, 4'd7);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, $urandom, 4'd7);
    // Clamp: 15 exceeds the DEPTH=12 and DEPTH=1 instances
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, $urandom, 4'd15);
    // Primed at delay 3, then saturation after many shifts
    step(0, 1, 0, 0, 32'h0, 4'd3);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, $urandom, 4'd3);
    step(0, 1, 1, 1, $urandom, 4'd3);
    for (int i = 0; i < 200; i++) step(0, 0, 1, 1, $urandom, 4'd3);
    step(0, 0, 0, 0, $urandom, 4'd15);
    // Random traffic
    sel = 4'd5;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) sel = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 9) < 7), 1'($urandom), $urandom, sel);
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
- Parametrised, runtime-selectable delay line for the OFDM RX datapath. It aligns sample streams, such as the correlator output against raw samples or CFO estimate against the data path.
- It generalises a single-stage enabled delay register to DEPTH stages, with a per-sample valid bit and a tap-select input. It also has a flush input for packet boundaries.
- It sits between sync/FFT blocks wherever a programmable, stall-aware alignment delay is needed.

Parameters:
- WIDTH, 32, data word width in bits (e.g. 16-bit I + 16-bit Q).
- DEPTH, 16, number of delay stages; legal range 1..256.
- SEL_W, $clog2(DEPTH) (min 1), width of dly_sel; derived, not to be overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  advance enable; the line shifts only on cycles with ena=1.
- flush  input  1  synchronous clear of all valid bits; data is kept.
- dly_sel  input  SEL_W  tap select; delay = dly_sel+1 enabled cycles.
- dat_in  input  WIDTH  input sample.
- val_in  input  1  input sample valid.
- dat_out  output  WIDTH  delayed sample.
- val_out  output  1  delayed valid.

Behaviour:
- Storage: DEPTH stages, each WIDTH data bits plus 1 valid bit; stage[0] is nearest the input.
- rst=1:
  - All stage data is cleared to 0 and all valid bits to 0.
  - From the next cycle, dat_out=0 and val_out=0.
  - rst has priority over flush and ena.
- flush=1 (rst=0):
  - All valid bits are cleared; data bits are unchanged.
  - flush has priority over ena. A sample presented in the flush cycle is dropped.
- ena=1 (rst=0, flush=0):
  - stage[0] <= {val_in, dat_in}.
  - stage[k] <= stage[k-1] for k=1..DEPTH-1.
- ena=0: all stages hold. There is no bubble insertion; the delay is counted in enabled cycles, not clocks.
- Output selection:
  - dat_out/val_out = stage[dly_sel], a combinational mux from registers only.
  - No combinational path exists from dat_in, val_in or ena to the outputs.
- Latency: a sample accepted on enabled cycle n appears at the outputs after enabled cycle n+dly_sel. This is dly_sel+1 enabled cycles.
- dly_sel=0 gives exactly one-register behaviour: an enabled D-flop with synchronous clear.
- dly_sel >= DEPTH (possible when DEPTH is not a power of 2): clamped to DEPTH-1.
- dly_sel change mid-stream:
  - The new tap is visible in the same cycle.
  - Samples may be skipped (delay decreased) or repeated (delay increased).
  - Software changes dly_sel only while flushed or idle; no protection logic is required.
- DEPTH=1: single stage; dly_sel is ignored (SEL_W=1, always clamped to 0).

Optional Feature:
- Macro DLY_PRIMED_EN.
- Defined:
  - Adds a fill counter fill_cnt of width $clog2(DEPTH+1) and an extra output port `primed  output  1`.
  - fill_cnt increments on each enabled shift and saturates at DEPTH.
  - fill_cnt is reset to 0 by rst or flush; flush wins over ena.
  - primed = (fill_cnt > clamped dly_sel), i.e. the selected tap holds a sample written since the last reset/flush.
- Undefined: no counter and no primed port; the rest of the behaviour is identical.

Decomposition:
- Shared package ofdm_rx_pkg provides:
  - the clog2-based width helper used for SEL_W and fill_cnt;
  - a common sample-width constant (SAMPLE_W=32) used as the WIDTH default at instantiation sites.
- Natural sub-module dly_stage:
  - One WIDTH+1 register with rst, flush (clears valid only) and ena.
  - Instantiated DEPTH times via generate.
- The top level holds the tap mux, the clamp logic and the optional fill counter.

Test Plan:
- Reset: drive dat_in=0xDEADBEEF, val_in=1, ena=1 with rst=1 for 3 cycles -> dat_out=0, val_out=0 throughout and 1 cycle after rst falls.
- Fixed delay: dly_sel=4, ena=1, val_in=1, dat_in=counter 1,2,3,... -> dat_out=1 with val_out=1 after the 5th edge; then consecutive values each cycle.
- Stall: dly_sel=2, ena pattern 1,0,0,1,1 with dat_in 0xA,x,x,0xB,0xC -> 0xA appears after the 3rd enabled edge (5th clock); outputs hold during ena=0.
- Flush: fill with valid data, dly_sel=7, assert flush 1 cycle -> val_out=0 next cycle with dat_out unchanged; val_out returns only after 8 new enabled samples.
- Clamp/edge (DEPTH=12): dly_sel=15 -> behaves as dly_sel=11, latency 12 enabled cycles; DEPTH=1 build -> latency 1 for any dly_sel.
- DLY_PRIMED_EN build, dly_sel=3: primed=0 after 3 enabled shifts, 1 after the 4th; flush -> primed=0 next cycle; 200 shifts -> fill_cnt saturates at DEPTH=16.
